// File: rtl/fns_pkg.sv
// -----------------------------------------------------------------------------
// fns_pkg
// Shared definitions for the Fibonacci-numeral-system (FNS) forbidden-pattern-
// free encoder:
//   fib(k)      : Fibonacci number, fib(1)=fib(2)=1 (64-bit, usable at
//                 elaboration time)
//   fpf_dw(n)   : binary data width needed to carry every codable value of an
//                 n-bit FPF code, clog2(fib(n+2))
//   fpf_max(n)  : largest codable value of an n-bit FPF code, fib(n+2)-1
//   fpf_state_e : encoder FSM states
// -----------------------------------------------------------------------------
package fns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fpf_state_e;

    function automatic logic [63:0] fib(input int k);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd0;  // fib(0)
        b = 64'd1;  // fib(1)
        for (int i = 1; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return (k <= 0) ? 64'd0 : b;
    endfunction

    function automatic int fpf_dw(input int n);
        return $clog2(fib(n + 2));
    endfunction

    function automatic logic [63:0] fpf_max(input int n);
        return fib(n + 2) - 64'd1;
    endfunction

endpackage

// File: rtl/fpf_bit_step.sv
// -----------------------------------------------------------------------------
// fpf_bit_step
// Combinational decision of one FPF code bit at position idx (idx >= 1).
//   residue      : value still to be represented by bits idx..0
//   idx          : bit position being decided
//   upper        : previously decided bit idx+1
//   top          : idx is the most significant code bit (no upper neighbour)
//   code_bit     : decided bit
//   residue_next : residue after removing this bit's weight fib(idx+1)
// -----------------------------------------------------------------------------
module fpf_bit_step
    import fns_pkg::*;
#(
    parameter int N  = 12,
    parameter int DW = fpf_dw(N),
    parameter int IW = $clog2(N)
) (
    input  logic [DW-1:0] residue,
    input  logic [IW-1:0] idx,
    input  logic          upper,
    input  logic          top,
    output logic          code_bit,
    output logic [DW-1:0] residue_next
);

    localparam int TBL = 2 ** IW;

    // Per-position thresholds: below lo the bit must be 0, at or above hi it
    // must be 1; in between either choice is codable, so the bit copies its
    // upper neighbour to avoid creating a 010/101 pattern. Table is padded to
    // a power of two so every idx value addresses a defined entry.
    logic [DW-1:0] lo_tbl [TBL];
    logic [DW-1:0] hi_tbl [TBL];

    generate
        for (genvar gi = 0; gi < TBL; gi++) begin : g_tbl
            if (gi < N) begin : g_used
                assign lo_tbl[gi] = DW'(fib(gi + 1));
                assign hi_tbl[gi] = DW'(fib(gi + 2));
            end else begin : g_pad
                assign lo_tbl[gi] = '0;
                assign hi_tbl[gi] = '0;
            end
        end
    endgenerate

    logic [DW-1:0] lo_thr;
    logic [DW-1:0] hi_thr;

    always_comb begin
        lo_thr = lo_tbl[idx];
        hi_thr = hi_tbl[idx];
        code_bit = 1'b0;
        if (residue >= hi_thr) begin
            code_bit = 1'b1;
        end else if (residue >= lo_thr) begin
            // The top bit has no neighbour above; treating it as 0 makes the
            // rule collapse to "1 iff residue >= fib(N+1)".
            code_bit = upper & ~top;
        end
        // Threshold was checked first, so this never underflows.
        residue_next = code_bit ? (residue - lo_thr) : residue;
    end

endmodule

// File: rtl/fpf_encoder_seq.sv
// -----------------------------------------------------------------------------
// fpf_encoder_seq
// Iterative FNS forbidden-pattern-free encoder: one code bit per clock, MSB
// first, with valid/ready handshakes on both sides.
//   clock      : sole clock
//   reset      : synchronous active-high reset
//   in_valid   : datain valid
//   in_ready   : word can be accepted this cycle
//   datain     : unsigned value, DW = clog2(fib(N+2)) bits
//   out_valid  : codeout/out_err hold a finished result
//   out_ready  : consumer takes the result this cycle
//   codeout    : N-bit FPF codeword
//   out_err    : datain exceeded fib(N+2)-1, codeout saturated to all ones
//   busy       : encoding in progress
// -----------------------------------------------------------------------------
module fpf_encoder_seq
    import fns_pkg::*;
#(
    parameter  int N  = 12,
    localparam int DW = fpf_dw(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] datain,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  codeout,
    output logic          out_err,
    output logic          busy
);

    localparam int            IW      = $clog2(N);
    localparam logic [DW-1:0] MAXV    = DW'(fpf_max(N));
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    generate
        if (N < 3 || N > 24) begin : g_bad_n
            $error("fpf_encoder_seq: N=%0d outside legal range 3..24", N);
        end
    endgenerate

    fpf_state_e    state_reg, state_next;
    logic [DW-1:0] residue_reg, residue_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [N-1:0]  code_reg, code_next;
    logic          err_reg, err_next;

    logic          accept;
    logic          load;
    logic          upper_bit;
    logic          step_bit;
    logic [DW-1:0] step_residue;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN);
    assign codeout   = code_reg;
    assign out_err   = err_reg;

    // Neighbour above the bit being decided.
    always_comb begin
        upper_bit = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (idx_reg == IW'(i)) begin
                upper_bit = code_reg[i + 1];
            end
        end
    end

    fpf_bit_step #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) u_step (
        .residue      (residue_reg),
        .idx          (idx_reg),
        .upper        (upper_bit),
        .top          (idx_reg == IDX_TOP),
        .code_bit     (step_bit),
        .residue_next (step_residue)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            residue_reg <= '0;
            idx_reg     <= '0;
            code_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            residue_reg <= residue_next;
            idx_reg     <= idx_next;
            code_reg    <= code_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        residue_next = residue_reg;
        idx_next     = idx_reg;
        code_next    = code_reg;
        err_next     = err_reg;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                load = accept;
            end
            RUN: begin
                code_next[idx_reg] = step_bit;
                residue_next       = step_residue;
                if (idx_reg == IDX_ONE) begin
                    // What is left (0 or 1) is exactly the weight-1 LSB.
                    code_next[0] = step_residue[0];
                    err_next     = 1'b0;
                    state_next   = DONE;
                end else begin
                    idx_next = idx_reg - IDX_ONE;
                end
            end
            DONE: begin
                if (accept) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            if (datain > MAXV) begin
                // Out-of-range words skip encoding and report at once.
                state_next = DONE;
                code_next  = '1;
                err_next   = 1'b1;
            end else begin
                state_next   = RUN;
                residue_next = datain;
                idx_next     = IDX_TOP;
                code_next    = '0;
                err_next     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpf_encoder_seq.sv
module tb_fpf_encoder_seq;
    import fns_pkg::*;

    localparam int DW12 = fpf_dw(12);
    localparam int DW3  = fpf_dw(3);
    localparam int DW8  = fpf_dw(8);

    typedef struct packed { logic [11:0] code; logic err; } exp12_t;
    typedef struct packed { logic [2:0]  code; logic err; } exp3_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // N=12 instance
    logic            iv12, ir12, ov12, or12, err12, busy12;
    logic [DW12-1:0] d12;
    logic [11:0]     c12;
    // N=3 instance
    logic            iv3, ir3, ov3, or3, err3, busy3;
    logic [DW3-1:0]  d3;
    logic [2:0]      c3;
    // N=8 instance
    logic            iv8, ir8, ov8, or8, err8, busy8;
    logic [DW8-1:0]  d8;
    logic [7:0]      c8;

    fpf_encoder_seq #(.N(12)) u12 (
        .clock(clock), .reset(reset), .in_valid(iv12), .in_ready(ir12), .datain(d12),
        .out_valid(ov12), .out_ready(or12), .codeout(c12), .out_err(err12), .busy(busy12)
    );
    fpf_encoder_seq #(.N(3)) u3 (
        .clock(clock), .reset(reset), .in_valid(iv3), .in_ready(ir3), .datain(d3),
        .out_valid(ov3), .out_ready(or3), .codeout(c3), .out_err(err3), .busy(busy3)
    );
    fpf_encoder_seq #(.N(8)) u8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .datain(d8),
        .out_valid(ov8), .out_ready(or8), .codeout(c8), .out_err(err8), .busy(busy8)
    );

    exp12_t q12[$];
    exp3_t  q3[$];
    int     q8[$];

    exp12_t m12_e;
    exp3_t  m3_e;
    int     m8_v;
    int     m8_sum;
    logic   m8_pat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int fibw(input int k);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 1; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Output monitors: pop the scoreboard on each output handshake.
    always @(negedge clock) begin
        if (!reset && ov12 && or12) begin
            if (q12.size() == 0) begin
                check("unexpected12", 64'(ov12), 64'd0);
            end else begin
                m12_e = q12.pop_front();
                $display("N=12 result code=0x%03h err=%0d (want 0x%03h/%0d)", c12, err12, m12_e.code, m12_e.err);
                check("code12", 64'(c12), 64'(m12_e.code));
                check("err12", 64'(err12), 64'(m12_e.err));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && ov3 && or3) begin
            if (q3.size() == 0) begin
                check("unexpected3", 64'(ov3), 64'd0);
            end else begin
                m3_e = q3.pop_front();
                $display("N=3 result code=%03b err=%0d in_ready=%0d", c3, err3, ir3);
                check("code3", 64'(c3), 64'(m3_e.code));
                check("err3", 64'(err3), 64'(m3_e.err));
                check("in_ready3_done", 64'(ir3), 64'd1);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && ov8 && or8) begin
            if (q8.size() == 0) begin
                check("unexpected8", 64'(ov8), 64'd0);
            end else begin
                m8_v   = q8.pop_front();
                m8_sum = int'(c8[0]);
                for (int k = 1; k < 8; k++) begin
                    if (c8[k]) m8_sum += fibw(k + 1);
                end
                m8_pat = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    if ({c8[k+2], c8[k+1], c8[k]} == 3'b010 || {c8[k+2], c8[k+1], c8[k]} == 3'b101)
                        m8_pat = 1'b1;
                end
                $display("N=8 in=%0d code=%08b err=%0d decoded=%0d", m8_v, c8, err8, m8_sum);
                if (m8_v <= 54) begin
                    check("decode8", 64'(m8_sum), 64'(m8_v));
                    check("pattern8", 64'(m8_pat), 64'd0);
                    check("err8", 64'(err8), 64'd0);
                end else begin
                    check("sat8", 64'(c8), 64'hFF);
                    check("err8_range", 64'(err8), 64'd1);
                end
            end
        end
    end

    task automatic wait_accept12();
        int n = 0;
        @(negedge clock);
        while (!ir12 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("accept12_timeout", 64'(ir12), 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid12();
        int n = 0;
        @(negedge clock);
        while (!ov12 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("valid12_timeout", 64'(ov12), 64'd1);
    endtask

    // Send one word on N=12 and measure edges from accept to out_valid.
    task automatic send12(input int v, input logic [11:0] code, input logic err, input int lat);
        int n = 0;
        iv12 = 1'b1;
        d12  = DW12'(v);
        q12.push_back(exp12_t'{code, err});
        wait_accept12();
        iv12 = 1'b0;
        @(negedge clock);
        while (!ov12 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("latency12_%0d", v), 64'(n), 64'(lat));
        @(posedge clock);
        #1;
    endtask

    int          vals3 [4] = '{1, 2, 3, 4};
    logic [2:0]  codes3[4] = '{3'b001, 3'b011, 3'b110, 3'b111};
    time         t_prev;
    time         t_acc;
    int          n;

    initial begin
        iv12 = 1'b0; d12 = '0; or12 = 1'b1;
        iv3  = 1'b0; d3  = '0; or3  = 1'b1;
        iv8  = 1'b0; d8  = '0; or8  = 1'b1;
        t_prev = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_code12", 64'(c12), 64'd0);
        check("reset_valid12", 64'(ov12), 64'd0);
        check("reset_err12", 64'(err12), 64'd0);
        check("reset_busy12", 64'(busy12), 64'd0);
        check("reset_ready12", 64'(ir12), 64'd1);
        check("reset_valid3", 64'(ov3), 64'd0);
        check("reset_valid8", 64'(ov8), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed N=12 words.
        send12(232, 12'h7FF, 1'b0, 11);
        send12(233, 12'hC00, 1'b0, 11);
        send12(0,   12'h000, 1'b0, 11);
        send12(376, 12'hFFF, 1'b0, 11);
        send12(377, 12'hFFF, 1'b1, 0);

        // Backpressure: hold result for 5 cycles, then release with a new word.
        or12 = 1'b0;
        iv12 = 1'b1;
        d12  = DW12'(233);
        q12.push_back(exp12_t'{12'hC00, 1'b0});
        wait_accept12();
        iv12 = 1'b0;
        wait_valid12();
        repeat (5) begin
            check("bp_code12", 64'(c12), 64'hC00);
            check("bp_valid12", 64'(ov12), 64'd1);
            check("bp_ready12", 64'(ir12), 64'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        or12 = 1'b1;
        iv12 = 1'b1;
        d12  = DW12'(0);
        q12.push_back(exp12_t'{12'h000, 1'b0});
        @(negedge clock);
        check("bp_release_ready12", 64'(ir12), 64'd1);
        @(posedge clock);
        #1;
        iv12 = 1'b0;
        @(negedge clock);
        check("bp_reload_valid12", 64'(ov12), 64'd0);
        check("bp_reload_busy12", 64'(busy12), 64'd1);
        wait_valid12();
        @(posedge clock);
        #1;

        // Reset in the middle of a word (RUN, idx=5).
        iv12 = 1'b1;
        d12  = DW12'(232);
        wait_accept12();
        iv12 = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("midrun_busy12", 64'(busy12), 64'd1);
        check("midrun_ready12", 64'(ir12), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_valid12", 64'(ov12), 64'd0);
        check("abort_code12", 64'(c12), 64'd0);
        check("abort_busy12", 64'(busy12), 64'd0);
        check("abort_ready12", 64'(ir12), 64'd1);
        @(posedge clock);
        #1;
        send12(232, 12'h7FF, 1'b0, 11);

        // N=3 back-to-back, one word every 3 cycles.
        iv3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d3 = DW3'(vals3[i]);
            q3.push_back(exp3_t'{codes3[i], 1'b0});
            n = 0;
            @(negedge clock);
            while (!ir3 && n < 50) begin
                @(negedge clock);
                n++;
            end
            if (n >= 50) check("accept3_timeout", 64'(ir3), 64'd1);
            @(posedge clock);
            t_acc = $time;
            #1;
            if (i > 0) check($sformatf("gap3_%0d", i), 64'(t_acc - t_prev), 64'd30);
            t_prev = t_acc;
        end
        iv3 = 1'b0;

        // N=8 exhaustive sweep plus the first out-of-range value.
        iv8 = 1'b1;
        for (int v = 0; v <= 55; v++) begin
            d8 = DW8'(v);
            q8.push_back(v);
            n = 0;
            @(negedge clock);
            while (!ir8 && n < 50) begin
                @(negedge clock);
                n++;
            end
            if (n >= 50) check("accept8_timeout", 64'(ir8), 64'd1);
            @(posedge clock);
            #1;
        end
        iv8 = 1'b0;

        // Drain all scoreboards.
        n = 0;
        while ((q12.size() + q3.size() + q8.size()) != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain12", 64'(q12.size()), 64'd0);
        check("drain3", 64'(q3.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
